// File: rtl/usb_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_arb_pkg
// Purpose  : Shared state encodings, arbitration mode constants and the
//            channel-index width helper for the USB transmit-wire arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package usb_tx_arb_pkg;

  // Arbiter state encodings
  localparam logic [1:0] ST_INIT   = 2'b00;
  localparam logic [1:0] ST_IDLE   = 2'b01;
  localparam logic [1:0] ST_ACTIVE = 2'b10;
  localparam logic [1:0] ST_GAP    = 2'b11;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of the idle-gap down-counter (IDLE_GAP up to 15)
  localparam int GAP_W = 4;

  // Width of a channel index; never narrower than one bit
  function automatic int ch_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_arb_pick
// Purpose  : Combinational winner picker. Fixed mode returns the lowest
//            asserted request; round-robin mode returns the first asserted
//            request at or above rr_ptr_i, wrapping modulo NUM_CH.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_arb_pick
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int RR_EN  = ARB_FIXED,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [CH_W-1:0]   winner_o,
  output logic              valid_o
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap
  localparam int SW = CH_W + 1;

  assign valid_o = |req_i;

  generate
    if (RR_EN == ARB_RR) begin : g_rr
      // Walk the rotated order from its far end so the candidate nearest rr_ptr wins
      always_comb begin
        logic [SW-1:0]   sum;
        logic [CH_W-1:0] idx;
        sum      = '0;
        idx      = '0;
        winner_o = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          sum = {1'b0, rr_ptr_i} + SW'(k);
          if (sum >= SW'(NUM_CH)) begin
            sum = sum - SW'(NUM_CH);
          end
          idx = sum[CH_W-1:0];
          if (req_i[idx]) begin
            winner_o = idx;
          end
        end
      end
    end else begin : g_fixed
      // The rotation pointer has no meaning in fixed-priority mode
      logic unused_ptr;
      assign unused_ptr = ^rr_ptr_i;

      // Scan downward so the lowest asserted index is the last one written
      always_comb begin
        winner_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (req_i[i]) begin
            winner_o = CH_W'(i);
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/usb_tx_wire_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_wire_arb_n
// Purpose  : Arbitrates NUM_CH transmit sources onto the single usbTxWire
//            write interface. Fixed-priority or round-robin selection, an
//            optional idle gap between ownerships, gated per-channel ready,
//            and forced-idle wire outputs whenever no grant is held.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_wire_arb_n
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 2,
  parameter int RR_EN    = ARB_FIXED,
  parameter int IDLE_GAP = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_req,
  output logic [NUM_CH-1:0]             ch_gnt,
  input  logic [NUM_CH-1:0]             ch_wen,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data,
  input  logic [NUM_CH-1:0]             ch_ctl,
  output logic [NUM_CH-1:0]             ch_rdy,
  input  logic                          wire_rdy_in,
  output logic [DATA_W-1:0]             tx_bits,
  output logic                          tx_ctl,
  output logic                          tx_wen,
  output logic                          busy,
  output logic [ch_width(NUM_CH)-1:0]   active_ch
);

  localparam int               CH_W     = ch_width(NUM_CH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  logic [1:0]        state_q,  state_d;
  logic [NUM_CH-1:0] gnt_q,    gnt_d;
  logic [CH_W-1:0]   sel_q,    sel_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]  gap_q,    gap_d;
  logic              busy_q,   busy_d;

  logic [CH_W-1:0]   pick_winner;
  logic              pick_valid;

  usb_tx_arb_pick #(
    .NUM_CH (NUM_CH),
    .RR_EN  (RR_EN),
    .CH_W   (CH_W)
  ) u_pick (
    .req_i    (ch_req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  // State register: reset drops any grant immediately, no transfer completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      gnt_q    <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: grant only from IDLE, release when the owner drops its request
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_ACTIVE;
          gnt_d    = NUM_CH'(1) << pick_winner;
          sel_d    = pick_winner;
          busy_d   = 1'b1;
          rr_ptr_d = (pick_winner == LAST_CH) ? '0 : pick_winner + CH_W'(1);
        end
      end
      ST_ACTIVE: begin
        // Other channels' requests are deliberately ignored here: no preemption
        if (!ch_req[sel_q]) begin
          gnt_d  = '0;
          sel_d  = '0;
          busy_d = 1'b0;
          if (IDLE_GAP > 0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // Leaving on a count of 1 gives exactly IDLE_GAP cycles in GAP
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Output logic: only the granted channel reaches the wire, otherwise idle
  always_comb begin
    tx_wen  = 1'b0;
    tx_bits = '0;
    tx_ctl  = 1'b0;
    if (busy_q) begin
      tx_wen  = ch_wen[sel_q];
      tx_bits = ch_data[int'(sel_q) * DATA_W +: DATA_W];
      tx_ctl  = ch_ctl[sel_q];
    end
  end

  assign ch_gnt    = gnt_q;
  assign ch_rdy    = {NUM_CH{wire_rdy_in}} & gnt_q;
  assign busy      = busy_q;
  assign active_ch = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_wire_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_wire_arb_n
// Purpose  : Directed self-checking bench for usb_tx_wire_arb_n. Three
//            instances: A (4 ch, fixed, no gap), B (4 ch, round robin,
//            no gap), C (2 ch, fixed, gap of 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_wire_arb_n;

  logic clk;
  logic rst;
  logic rdy;

  int total;
  int bad;

  // Instance A
  logic [3:0] a_req, a_gnt, a_wen, a_ctl, a_rdy;
  logic [7:0] a_data;
  logic [1:0] a_bits, a_act;
  logic       a_txctl, a_txwen, a_busy;

  // Instance B
  logic [3:0] b_req, b_gnt, b_wen, b_ctl, b_rdy;
  logic [7:0] b_data;
  logic [1:0] b_bits, b_act;
  logic       b_txctl, b_txwen, b_busy;

  // Instance C
  logic [1:0] c_req, c_gnt, c_wen, c_ctl, c_rdy;
  logic [3:0] c_data;
  logic [1:0] c_bits;
  logic       c_act;
  logic       c_txctl, c_txwen, c_busy;

  usb_tx_wire_arb_n #(.NUM_CH(4), .DATA_W(2), .RR_EN(0), .IDLE_GAP(0)) u_a (
    .clk(clk), .rst(rst), .ch_req(a_req), .ch_gnt(a_gnt), .ch_wen(a_wen),
    .ch_data(a_data), .ch_ctl(a_ctl), .ch_rdy(a_rdy), .wire_rdy_in(rdy),
    .tx_bits(a_bits), .tx_ctl(a_txctl), .tx_wen(a_txwen), .busy(a_busy),
    .active_ch(a_act)
  );

  usb_tx_wire_arb_n #(.NUM_CH(4), .DATA_W(2), .RR_EN(1), .IDLE_GAP(0)) u_b (
    .clk(clk), .rst(rst), .ch_req(b_req), .ch_gnt(b_gnt), .ch_wen(b_wen),
    .ch_data(b_data), .ch_ctl(b_ctl), .ch_rdy(b_rdy), .wire_rdy_in(rdy),
    .tx_bits(b_bits), .tx_ctl(b_txctl), .tx_wen(b_txwen), .busy(b_busy),
    .active_ch(b_act)
  );

  usb_tx_wire_arb_n #(.NUM_CH(2), .DATA_W(2), .RR_EN(0), .IDLE_GAP(3)) u_c (
    .clk(clk), .rst(rst), .ch_req(c_req), .ch_gnt(c_gnt), .ch_wen(c_wen),
    .ch_data(c_data), .ch_ctl(c_ctl), .ch_rdy(c_rdy), .wire_rdy_in(rdy),
    .tx_bits(c_bits), .tx_ctl(c_txctl), .tx_wen(c_txwen), .busy(c_busy),
    .active_ch(c_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rr_order [5];
    rr_order = '{0, 1, 2, 3, 0};
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    rdy    = 1'b0;
    a_req  = '0; a_wen = '0; a_ctl = '0; a_data = '0;
    b_req  = '0; b_wen = '0; b_ctl = '0; b_data = '0;
    c_req  = '0; c_ctl = '0; c_data = '0;
    c_wen  = 2'b11;   // wire must stay idle during reset regardless

    // ---- reset held for three cycles ----
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_c_gnt", c_gnt, 2'b00);
      chk("rst_c_txwen", c_txwen, 1'b0);
      chk("rst_c_busy", c_busy, 1'b0);
    end
    chk("rst_c_act", c_act, 1'b0);
    chk("rst_c_bits", c_bits, 2'b00);
    chk("rst_a_gnt", a_gnt, 4'b0000);
    chk("rst_b_gnt", b_gnt, 4'b0000);

    rst   = 1'b0;
    c_wen = 2'b00;
    c_req = 2'b01;

    // first edge: INIT -> IDLE, no grant yet
    tick();
    chk("init_c_gnt", c_gnt, 2'b00);
    // second edge: grant to ch0
    tick();
    chk("first_c_gnt", c_gnt, 2'b01);
    chk("first_c_busy", c_busy, 1'b1);
    chk("first_c_act", c_act, 1'b0);

    // ---- idle gap of 3: ch0 releases while ch1 requests ----
    c_req = 2'b10;
    tick();   // edge k: release
    chk("gap_k0_gnt", c_gnt, 2'b00);
    chk("gap_k0_busy", c_busy, 1'b0);
    tick();
    chk("gap_k1_gnt", c_gnt, 2'b00);
    tick();
    chk("gap_k2_gnt", c_gnt, 2'b00);
    // drive both channels before the grant; wire must stay idle until granted
    c_wen  = 2'b11;
    c_data = 4'b1001;   // ch1 = 2'b10, ch0 = 2'b01
    c_ctl  = 2'b10;
    rdy    = 1'b1;
    #1;
    chk("gap_idle_txwen", c_txwen, 1'b0);
    chk("gap_idle_bits", c_bits, 2'b00);
    chk("gap_idle_rdy", c_rdy, 2'b00);
    tick();
    chk("gap_k3_gnt", c_gnt, 2'b00);
    tick();   // edge k+4: regrant to ch1
    chk("gap_k4_gnt", c_gnt, 2'b10);
    chk("gap_k4_act", c_act, 1'b1);

    // ---- muxing with ch1 granted ----
    chk("mux_txwen", c_txwen, 1'b1);
    chk("mux_bits", c_bits, 2'b10);
    chk("mux_ctl", c_txctl, 1'b1);
    chk("mux_rdy", c_rdy, 2'b10);
    rdy = 1'b0;
    #1;
    chk("mux_rdy_low", c_rdy, 2'b00);
    c_wen = 2'b01;   // ungranted ch0 still enabled; granted ch1 idle
    #1;
    chk("mux_ungranted_wen", c_txwen, 1'b0);
    chk("mux_ungranted_bits", c_bits, 2'b10);

    // ---- reset pulse mid-ACTIVE on ch1 ----
    rst = 1'b1;
    tick();
    chk("midrst_gnt", c_gnt, 2'b00);
    chk("midrst_txwen", c_txwen, 1'b0);
    chk("midrst_busy", c_busy, 1'b0);
    rst = 1'b0;
    tick();   // INIT
    chk("midrst_init_gnt", c_gnt, 2'b00);
    tick();   // regrant to ch1
    chk("midrst_regrant", c_gnt, 2'b10);
    c_req = 2'b00;
    c_wen = 2'b00;
    tick();

    // ---- fixed priority on four channels ----
    a_req = 4'b1010;
    tick();
    chk("fix_gnt1", a_gnt, 4'b0010);
    chk("fix_act1", a_act, 2'd1);
    a_req = 4'b1000;
    tick();
    chk("fix_rel_gnt", a_gnt, 4'b0000);
    tick();
    chk("fix_gnt3", a_gnt, 4'b1000);
    chk("fix_act3", a_act, 2'd3);
    a_req = 4'b1111;   // ch3 still owns it: no preemption by ch0
    tick();
    chk("fix_nopreempt", a_gnt, 4'b1000);
    a_req = 4'b0111;
    tick();
    chk("fix_rel2_gnt", a_gnt, 4'b0000);
    tick();
    chk("fix_gnt0", a_gnt, 4'b0001);
    a_req = 4'b0000;
    tick();

    // ---- round robin, all four requesting, 0,1,2,3,0 ----
    b_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_grant", b_gnt, 32'(4'b0001 << rr_order[n]));
      chk("rr_act", b_act, 32'(rr_order[n]));
      if (n < 4) begin
        tick();
        tick();
        chk("rr_hold", b_gnt, 32'(4'b0001 << rr_order[n]));
        b_req[rr_order[n]] = 1'b0;
        tick();
        chk("rr_release", b_gnt, 4'b0000);
        b_req[rr_order[n]] = 1'b1;
      end
    end
    b_req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
